peripheral_spram_ctrl_ahb3: RTL and testbench
=============================================

// Module: peripheral_spram_ctrl_ahb3
// PURPOSE
//  AHB3-Lite slave front-end that sequences one peripheral_ram_generic_ahb3 instance (byte-write, 1-cycle read latency).
//  Decodes HADDR/HSIZE into word address and byte lanes, and issues zero-wait writes and zero-wait reads.
//  Resolves the read-after-write hazard with a single stall cycle.
//  Rejects illegal accesses with the two-cycle AHB ERROR response.
// PARAMETERS
//  DEPTH    256            RAM depth in 32-bit words
//  AW       $clog2(DEPTH)  RAM word-address width
//  DW       32             data width; only 32 is supported
// PORTS
//  HCLK       in   1   clock; all state on rising edge
//  HRESETn    in   1   asynchronous, active-low reset
//  HSEL       in   1   slave select
//  HADDR      in   32  byte address
//  HWRITE     in   1   1=write, 0=read
//  HSIZE      in   3   0=byte, 1=half, 2=word, others illegal
//  HTRANS     in   2   IDLE/BUSY/NONSEQ/SEQ
//  HWDATA     in   DW  write data (data phase)
//  HREADY     in   1   bus ready (address phase qualifier)
//  HREADYOUT  out  1   slave ready
//  HRESP      out  1   0=OKAY, 1=ERROR
//  HRDATA     out  DW  read data
//  ram_we     out  4   byte write enables to RAM
//  ram_din    out  DW  RAM write data
//  ram_waddr  out  AW  RAM write word address
//  ram_raddr  out  AW  RAM read word address
//  ram_dout   in   DW  RAM read data, valid 1 cycle after ram_raddr
// BEHAVIOUR
//  Reset values:
//   - HREADYOUT=1, HRESP=0, HRDATA=0, ram_we=0, state=IDLE, latched addr/lanes=0.
//   - A reset mid-transfer aborts it; no RAM write is issued.
//  Transfer acceptance:
//   - A transfer is accepted when HSEL & HREADY & HTRANS[1].
//   - The accept cycle latches word addr HADDR[AW+1:2], byte lanes and HWRITE.
//   - IDLE/BUSY, or an unselected bus, gives an OKAY zero-wait response with no RAM access.
//  Byte lanes:
//   - HSIZE=0: 1<<HADDR[1:0].
//   - HSIZE=1: HADDR[1] ? 4'b1100 : 4'b0011.
//   - HSIZE=2: 4'b1111.
//  Illegal access, which leads to ERR1:
//   - HSIZE>2.
//   - HSIZE=1 with HADDR[0]=1.
//   - HSIZE=2 with HADDR[1:0]!=0.
//   - HADDR[31:2] >= DEPTH.
//  States:
//   - IDLE: HREADYOUT=1. An accept goes to WRITE, READ, or ERR1.
//   - WRITE (data phase): ram_we=lanes, ram_din=HWDATA, ram_waddr=latched; HREADYOUT=1. The RAM writes at the end of this cycle.
//       The next state is chosen from the new address phase, the same as from IDLE.
//       The write address and lanes are also recorded in the hazard register (hz_valid=1, hz_addr).
//   - READ (data phase): HRDATA=ram_dout, HREADYOUT=1.
//       The address phase of the accepted read drives ram_raddr=HADDR[AW+1:2] combinationally, so data is ready here.
//   - RAW: entered instead of READ when the read is accepted during a WRITE data phase to the same word.
//       HREADYOUT=0 and ram_raddr=latched addr; the next state is READ, which returns the updated data.
//       A read after a write to a different word does not stall.
//   - ERR1: HREADYOUT=0, HRESP=1, then ERR2.
//   - ERR2: HREADYOUT=1, HRESP=1, then back to decode as in IDLE. No RAM write occurs for an erroneous transfer.
//  Datapath rules:
//   - ram_we=0 in every state except WRITE.
//   - ram_raddr otherwise follows HADDR[AW+1:2], which is harmless.
//   - HRDATA holds its last value outside READ.
//   - Back-to-back writes and back-to-back reads are sustained at 1 transfer per cycle.
// STRUCTURE
//  Package peripheral_spram_ahb3_pkg holds:
//   - HTRANS_IDLE/BUSY/NONSEQ/SEQ, HSIZE_BYTE/HALF/WORD, HRESP_OKAY/ERROR.
//   - typedef enum logic [2:0] {IDLE, WRITE, READ, RAW, ERR1, ERR2} spram_ctrl_state_t.
//  Sub-module peripheral_spram_ahb3_lane_decode (combinational): HADDR[1:0], HSIZE -> lanes[3:0], misaligned.
//  The FSM and hazard register stay in this module.
// TESTING
//  Bench instantiates this block with peripheral_ram_generic_ahb3, DEPTH=256.
//  1. Reset: HRESETn=0 mid-write -> HREADYOUT=1, HRESP=0, ram_we=0; a read of that word after release returns the pre-write value.
//  2. Word write 0xDEADBEEF to 0x10, then read 0x10 on the next transfer -> one stall cycle (HREADYOUT=0), then HRDATA=0xDEADBEEF, OKAY.
//  3. Byte write 0xAA to 0x13 over word 0x11223344 -> ram_we=4'b1000; word read then returns 0xAA223344.
//  4. Burst of 4 SEQ word writes then 4 SEQ reads at 0x20..0x2C -> zero wait states on writes; the first read stalls only if its word equals the last write.
//  5. HSIZE=2 at 0x02, and a word access at 0x400 (>= DEPTH*4) -> two-cycle ERROR (HREADYOUT 0 then 1, HRESP=1); RAM contents unchanged.
//  6. HTRANS=BUSY, or HSEL=0 with active HTRANS -> OKAY, zero wait, ram_we=0.

Source files
------------

// File: rtl/peripheral_spram_ahb3_pkg.sv
// Shared AHB3-Lite encodings and controller state type for the single-port RAM front-end.
package peripheral_spram_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {IDLE, WRITE, READ, RAW, ERR1, ERR2} spram_ctrl_state_t;

endpackage

// File: rtl/peripheral_ram_generic_ahb3.sv
// Generic byte-writable RAM with one write port and a registered (1-cycle) read port.
module peripheral_ram_generic_ahb3 #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned DW    = 32
) (
    input  logic              clk,
    input  logic [DW/8-1:0]   we,
    input  logic [DW-1:0]     din,
    input  logic [AW-1:0]     waddr,
    input  logic [AW-1:0]     raddr,
    output logic [DW-1:0]     dout
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DW / 8); i++) begin
            if (we[i]) begin
                mem[waddr][8*i +: 8] <= din[8*i +: 8];
            end
        end
        dout <= mem[raddr];
    end

endmodule

// File: rtl/peripheral_spram_ahb3_lane_decode.sv
// Maps the low address bits and HSIZE onto 32-bit byte lanes and flags illegal size/alignment.
module peripheral_spram_ahb3_lane_decode
    import peripheral_spram_ahb3_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [2:0] size,
    output logic [3:0] lanes,
    output logic       misaligned
);

    always_comb begin
        lanes      = 4'b0000;
        misaligned = 1'b0;
        case (size)
            HSIZE_BYTE: lanes = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                lanes      = addr_lo[1] ? 4'b1100 : 4'b0011;
                misaligned = addr_lo[0];
            end
            HSIZE_WORD: begin
                lanes      = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
            // Sizes above a word are never legal on a 32-bit bus.
            default:    misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/peripheral_spram_ctrl_ahb3.sv
// AHB3-Lite slave sequencing a byte-write RAM: zero-wait reads/writes, one stall on a
// read of the word being written, two-cycle ERROR for illegal accesses.
module peripheral_spram_ctrl_ahb3
    import peripheral_spram_ahb3_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned DW    = 32
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [1:0]    HTRANS,
    input  logic [DW-1:0] HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [DW-1:0] HRDATA,
    output logic [3:0]    ram_we,
    output logic [DW-1:0] ram_din,
    output logic [AW-1:0] ram_waddr,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_dout
);

    spram_ctrl_state_t state, decode_state;
    logic [AW-1:0]     addr_q, hz_addr, haddr_word;
    logic [3:0]        lanes_q, lanes;
    logic              write_q, hz_valid;
    logic [DW-1:0]     hrdata_q;
    logic              accept, misaligned, out_of_range, hazard;

    peripheral_spram_ahb3_lane_decode u_lane_decode (
        .addr_lo    (HADDR[1:0]),
        .size       (HSIZE),
        .lanes      (lanes),
        .misaligned (misaligned)
    );

    assign accept       = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    assign haddr_word   = HADDR[AW+1:2];
    assign out_of_range = ({2'b00, HADDR[31:2]} >= DEPTH);
    // A read of the word being written this cycle would see stale RAM data.
    assign hazard       = (state == WRITE) && (haddr_word == addr_q);

    always_comb begin
        decode_state = IDLE;
        if (accept) begin
            if (misaligned || out_of_range) begin
                decode_state = ERR1;
            end else if (HWRITE) begin
                decode_state = WRITE;
            end else if (hazard) begin
                decode_state = RAW;
            end else begin
                decode_state = READ;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= IDLE;
            addr_q   <= '0;
            lanes_q  <= '0;
            write_q  <= 1'b0;
            hz_valid <= 1'b0;
            hz_addr  <= '0;
            hrdata_q <= '0;
        end else begin
            hz_valid <= (state == WRITE);
            if (state == WRITE) begin
                hz_addr <= addr_q;
            end
            if (state == READ) begin
                hrdata_q <= ram_dout;
            end
            case (state)
                RAW:     state <= READ;
                ERR1:    state <= ERR2;
                default: begin
                    state <= decode_state;
                    if (accept) begin
                        addr_q  <= haddr_word;
                        lanes_q <= lanes;
                        write_q <= HWRITE;
                    end
                end
            endcase
        end
    end

    assign HREADYOUT = !(state == RAW || state == ERR1);
    assign HRESP     = (state == ERR1 || state == ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = (state == READ) ? ram_dout : hrdata_q;
    assign ram_we    = (state == WRITE && write_q) ? lanes_q : 4'b0000;
    assign ram_din   = HWDATA;
    assign ram_waddr = addr_q;
    // During the stall cycle re-read the just-written word so READ returns fresh data.
    assign ram_raddr = (state == RAW && hz_valid) ? hz_addr : haddr_word;

endmodule

// File: tb/tb_peripheral_spram_ctrl_ahb3.sv
// Self-checking bench: pipelined AHB driver, byte-lane memory model and read-data scoreboard.
module tb_peripheral_spram_ctrl_ahb3;
    import peripheral_spram_ahb3_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;

    logic          hclk = 1'b0;
    logic          hresetn;
    logic          hsel, hwrite, hready, hreadyout, hresp;
    logic [31:0]   haddr, hwdata, hrdata, ram_din, ram_dout;
    logic [2:0]    hsize;
    logic [1:0]    htrans;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_waddr, ram_raddr;

    always #5 hclk = ~hclk;
    assign hready = hreadyout;

    peripheral_spram_ctrl_ahb3 #(.DEPTH(DEPTH)) dut (
        .HCLK      (hclk),
        .HRESETn   (hresetn),
        .HSEL      (hsel),
        .HADDR     (haddr),
        .HWRITE    (hwrite),
        .HSIZE     (hsize),
        .HTRANS    (htrans),
        .HWDATA    (hwdata),
        .HREADY    (hready),
        .HREADYOUT (hreadyout),
        .HRESP     (hresp),
        .HRDATA    (hrdata),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_waddr (ram_waddr),
        .ram_raddr (ram_raddr),
        .ram_dout  (ram_dout)
    );

    peripheral_ram_generic_ahb3 #(.DEPTH(DEPTH)) u_ram (
        .clk   (hclk),
        .we    (ram_we),
        .din   (ram_din),
        .waddr (ram_waddr),
        .raddr (ram_raddr),
        .dout  (ram_dout)
    );

    typedef enum int {DP_NONE, DP_WRITE, DP_READ, DP_ERR} dp_t;

    dp_t         dp_kind;
    int unsigned dp_word;
    logic [3:0]  dp_lanes;
    logic [31:0] model [DEPTH];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [3:0] tb_lanes(input logic [2:0] size, input logic [1:0] a);
        if (size == 3'd0) return 4'b0001 << a;
        if (size == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic tb_illegal(input logic [2:0] size, input logic [31:0] a);
        return (size > 3'd2) || (size == 3'd1 && a[0]) || (size == 3'd2 && a[1:0] != 2'b00)
               || (a[31:2] >= DEPTH);
    endfunction

    // Drives one address phase (plus HWDATA of the previous data phase) and holds it
    // until the slave is ready; reports on the previous data phase.
    task automatic bus(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                       output int waits, output logic resp_first, output logic resp_last,
                       output logic [3:0] we_seen);
        logic        rdy, done, acc;
        logic [31:0] exp;
        if (dp_kind == DP_WRITE) begin
            for (int b = 0; b < 4; b++) begin
                if (dp_lanes[b]) model[dp_word][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        hsel = sel; htrans = trans; hwrite = wr; hsize = size; haddr = addr; hwdata = wdata;
        acc = sel && trans[1];
        if (acc && !wr && !tb_illegal(size, addr)) exp_q.push_back(model[addr[9:2]]);
        waits = 0; done = 1'b0; resp_first = 1'b0; resp_last = 1'b0; we_seen = 4'b0000;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge hclk);
            rdy = hreadyout;
            if (i == 0) resp_first = hresp;
            resp_last = hresp;
            we_seen   = we_seen | ram_we;
            if (rdy && dp_kind == DP_READ) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_underflow: read data %h with no expected value", hrdata);
                end else begin
                    exp = exp_q.pop_front();
                    if (hrdata !== exp) begin
                        n_fail++;
                        $display("FAIL read_data: HRDATA=%h expected %h", hrdata, exp);
                    end
                end
            end
            @(posedge hclk);
            #1;
            if (rdy) done = 1'b1;
            else     waits++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: HREADYOUT low for %0d cycles, expected release", waits);
        end
        if (!acc)                         dp_kind = DP_NONE;
        else if (tb_illegal(size, addr))  dp_kind = DP_ERR;
        else if (wr)                      dp_kind = DP_WRITE;
        else                              dp_kind = DP_READ;
        dp_word  = addr[9:2];
        dp_lanes = tb_lanes(size, addr[1:0]);
    endtask

    int         w;
    logic       rf, rl;
    logic [3:0] we;

    task automatic test_reset();
        hresetn = 1'b0; hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
        hsize = HSIZE_WORD; haddr = '0; hwdata = '0; dp_kind = DP_NONE;
        repeat (2) @(posedge hclk);
        #1;
        n_checks++; if (hreadyout !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout: %b expected 1", hreadyout); end
        n_checks++; if (hresp !== 1'b0) begin n_fail++; $display("FAIL reset_hresp: %b expected 0", hresp); end
        n_checks++; if (hrdata !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata: %h expected 0", hrdata); end
        n_checks++; if (ram_we !== 4'b0000) begin n_fail++; $display("FAIL reset_ram_we: %b expected 0000", ram_we); end
        @(negedge hclk) hresetn = 1'b1;
        @(posedge hclk); #1;
        bus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h40, 32'h0, w, rf, rl, we);
        bus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h12345678, w, rf, rl, we);
        bus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h40, 32'h0, w, rf, rl, we);
        // Now inside the WRITE data phase: abort it with reset.
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hCAFEF00D;
        #2 hresetn = 1'b0;
        #1;
        n_checks++; if (hreadyout !== 1'b1) begin n_fail++; $display("FAIL midreset_hreadyout: %b expected 1", hreadyout); end
        n_checks++; if (hresp !== 1'b0) begin n_fail++; $display("FAIL midreset_hresp: %b expected 0", hresp); end
        n_checks++; if (ram_we !== 4'b0000) begin n_fail++; $display("FAIL midreset_ram_we: %b expected 0000", ram_we); end
        dp_kind = DP_NONE;
        @(negedge hclk);
        @(negedge hclk) hresetn = 1'b1;
        @(posedge hclk); #1;
        bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40, 32'h0, w, rf, rl, we);
        bus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0, w, rf, rl, we);
    endtask

    task automatic test_raw_hazard();
        bus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'h0, w, rf, rl, we);
        bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'hDEADBEEF, w, rf, rl, we);
        n_checks++; if (w != 0) begin n_fail++; $display("FAIL raw_write_waits: %0d expected 0", w); end
        bus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0, w, rf, rl, we);
        n_checks++; if (w != 1) begin n_fail++; $display("FAIL raw_stall_cycles: %0d expected 1", w); end
        n_checks++; if (rl !== 1'b0) begin n_fail++; $display("FAIL raw_hresp: %b expected 0", rl); end
    endtask

    task automatic test_byte_write();
        bus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'h0, w, rf, rl, we);
        bus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h13, 32'h11223344, w, rf, rl, we);
        bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'hAA000000, w, rf, rl, we);
        n_checks++; if (we !== 4'b1000) begin n_fail++; $display("FAIL byte_lanes: ram_we=%b expected 1000", we); end
        bus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0, w, rf, rl, we);
        n_checks++; if (hrdata !== 32'hAA223344) begin n_fail++; $display("FAIL byte_merge_hold: HRDATA=%h expected aa223344", hrdata); end
    endtask

    task automatic test_back_to_back();
        int total = 0;
        for (int i = 0; i < 4; i++) begin
            bus(1'b1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1, HSIZE_WORD, 32'h20 + 4 * i,
                32'hB000_0000 | (i - 1), w, rf, rl, we);
            total += w;
        end
        for (int i = 0; i < 4; i++) begin
            bus(1'b1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h20 + 4 * i,
                32'hB000_0003, w, rf, rl, we);
            total += w;
        end
        bus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0, w, rf, rl, we);
        total += w;
        n_checks++; if (total != 0) begin n_fail++; $display("FAIL burst_wait_states: %0d expected 0", total); end
        n_checks++; if (hrdata !== 32'hB0000003) begin n_fail++; $display("FAIL burst_last_read: HRDATA=%h expected b0000003", hrdata); end
    endtask

    task automatic test_error();
        logic [31:0] bad_addr [3];
        logic [2:0]  bad_size [3];
        bad_addr[0] = 32'h02;  bad_size[0] = HSIZE_WORD;
        bad_addr[1] = 32'h400; bad_size[1] = HSIZE_WORD;
        bad_addr[2] = 32'h00;  bad_size[2] = 3'd3;
        bus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h00, 32'h0, w, rf, rl, we);
        bus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h55AA55AA, w, rf, rl, we);
        for (int i = 0; i < 3; i++) begin
            bus(1'b1, HTRANS_NONSEQ, 1'b1, bad_size[i], bad_addr[i], 32'h0, w, rf, rl, we);
            bus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'hFFFFFFFF, w, rf, rl, we);
            n_checks++; if (w != 1) begin n_fail++; $display("FAIL err%0d_waits: %0d expected 1", i, w); end
            n_checks++; if (rf !== 1'b1 || rl !== 1'b1) begin n_fail++; $display("FAIL err%0d_hresp: first=%b last=%b expected 1 1", i, rf, rl); end
            n_checks++; if (we !== 4'b0000) begin n_fail++; $display("FAIL err%0d_ram_we: %b expected 0000", i, we); end
            n_checks++; if (hresp !== 1'b0) begin n_fail++; $display("FAIL err%0d_hresp_after: %b expected 0", i, hresp); end
        end
        bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h00, 32'h0, w, rf, rl, we);
        bus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0, w, rf, rl, we);
    endtask

    task automatic test_idle_busy();
        bus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h30, 32'h0, w, rf, rl, we);
        bus(1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h30, 32'h01020304, w, rf, rl, we);
        bus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'hFFFFFFFF, w, rf, rl, we);
        n_checks++; if (w != 0 || rl !== 1'b0 || we !== 4'b0000) begin n_fail++;
            $display("FAIL busy_response: waits=%0d hresp=%b ram_we=%b expected 0 0 0000", w, rl, we); end
        bus(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h30, 32'h0, w, rf, rl, we);
        bus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'hFFFFFFFF, w, rf, rl, we);
        n_checks++; if (w != 0 || rl !== 1'b0 || we !== 4'b0000) begin n_fail++;
            $display("FAIL unselected_response: waits=%0d hresp=%b ram_we=%b expected 0 0 0000", w, rl, we); end
        bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h30, 32'h0, w, rf, rl, we);
        bus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0, w, rf, rl, we);
    endtask

    initial begin
        test_reset();
        test_raw_hazard();
        test_byte_write();
        test_back_to_back();
        test_error();
        test_idle_busy();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
